// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with a single register writeback per operation.
// Optional build macro DIV_FAST_SPECIAL_EN retires divide-by-zero, signed overflow and |rs1|<|rs2| straight from IDLE.
module div_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [1:0]            op,
    input  logic [XLEN-1:0]       rs1,
    input  logic [XLEN-1:0]       rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy,
    output logic                  ready,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       wd
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [1:0]              op_r;
    logic [REG_ADDR_W-1:0]   rd_r;
    logic [XLEN-1:0]         src1_r;
    logic [XLEN-1:0]         quo_r;
    logic [XLEN-1:0]         rem_r;
    logic [XLEN-1:0]         dvs_r;
    logic [XLEN-1:0]         result_r;
    logic                    neg_q_r;
    logic                    neg_r_r;
    logic                    div0_r;
    logic                    ovf_r;

    logic                    signed_op_s;
    logic                    rs1_neg_s;
    logic                    rs2_neg_s;
    logic [XLEN-1:0]         mag1_s;
    logic [XLEN-1:0]         mag2_s;
    logic                    div0_s;
    logic                    ovf_s;
    logic [XLEN:0]           rem_sh_s;
    logic [XLEN:0]           trial_s;

    // Special cases take priority; otherwise apply the sign fix-up to the unsigned quotient/remainder.
    function automatic logic [XLEN-1:0] pick_result(
        input logic [1:0]      sel_op,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] src1,
        input logic            neg_q,
        input logic            neg_r,
        input logic            div0,
        input logic            ovf
    );
        logic [XLEN-1:0] res;
        if (div0) begin
            res = sel_op[1] ? src1 : ALL_ONES;
        end else if (ovf) begin
            res = sel_op[1] ? ZERO : INT_MIN;
        end else if (sel_op[1]) begin
            res = neg_r ? (ZERO - rem) : rem;
        end else begin
            res = neg_q ? (ZERO - quo) : quo;
        end
        return res;
    endfunction

    // Operand conditioning for a new request and the single restoring step.
    always_comb begin
        signed_op_s = ~op[0];
        rs1_neg_s   = signed_op_s & rs1[XLEN-1];
        rs2_neg_s   = signed_op_s & rs2[XLEN-1];
        mag1_s      = rs1_neg_s ? (ZERO - rs1) : rs1;
        mag2_s      = rs2_neg_s ? (ZERO - rs2) : rs2;
        div0_s      = (rs2 == ZERO);
        ovf_s       = signed_op_s & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
        rem_sh_s    = {rem_r, quo_r[XLEN-1]};
        trial_s     = rem_sh_s - {1'b0, dvs_r};
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 2'b00;
            rd_r     <= {REG_ADDR_W{1'b0}};
            src1_r   <= ZERO;
            quo_r    <= ZERO;
            rem_r    <= ZERO;
            dvs_r    <= ZERO;
            result_r <= ZERO;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            we       <= 1'b0;
            A3       <= {REG_ADDR_W{1'b0}};
            wd       <= ZERO;
        end else begin
            ready <= 1'b0;
            we    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    busy <= valid;
                    if (valid) begin
                        op_r    <= op;
                        rd_r    <= rd;
                        src1_r  <= rs1;
                        quo_r   <= mag1_s;
                        dvs_r   <= mag2_s;
                        rem_r   <= ZERO;
                        cnt_r   <= {CNT_W{1'b0}};
                        neg_q_r <= rs1_neg_s ^ rs2_neg_s;
                        neg_r_r <= rs1_neg_s;
                        div0_r  <= div0_s;
                        ovf_r   <= ovf_s;
`ifdef DIV_FAST_SPECIAL_EN
                        if (div0_s || ovf_s || (mag1_s < mag2_s)) begin
                            // Quotient is zero and the remainder is the whole dividend.
                            result_r <= pick_result(op, ZERO, mag1_s, rs1, rs1_neg_s ^ rs2_neg_s,
                                                    rs1_neg_s, div0_s, ovf_s);
                            state_r  <= S_DONE;
                        end else begin
                            state_r  <= S_CALC;
                        end
`else
                        state_r <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (!trial_s[XLEN]) begin
                        rem_r <= trial_s[XLEN-1:0];
                    end else begin
                        rem_r <= rem_sh_s[XLEN-1:0];
                    end
                    quo_r <= {quo_r[XLEN-2:0], ~trial_s[XLEN]};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_STEP) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_r <= pick_result(op_r, quo_r, rem_r, src1_r, neg_q_r, neg_r_r, div0_r, ovf_r);
                    state_r  <= S_DONE;
                end
                S_DONE: begin
                    ready   <= 1'b1;
                    we      <= 1'b1;
                    wd      <= result_r;
                    A3      <= rd_r;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multicycle divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits directly upstream of the register file write port: it produces the write-enable, destination address and write data for one register writeback per operation.
- The control FSM launches an operation with a one-cycle request, then stalls until the one-cycle done pulse.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- REG_ADDR_W, 5, destination register address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  start request; sampled only in IDLE.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- rs1  input  XLEN  dividend.
- rs2  input  XLEN  divisor.
- rd  input  REG_ADDR_W  destination register, captured with the request.
- busy  output  1  high from acceptance until done, inclusive.
- ready  output  1  one-cycle done pulse.
- we  output  1  register write enable; equals ready.
- A3  output  REG_ADDR_W  captured rd; valid while ready=1.
- wd  output  XLEN  result; valid while ready=1.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy, ready, we = 0; A3, wd = 0; internal registers cleared.
  - Reset in any state aborts the operation with no writeback.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If valid=1 at edge N: latch op, rd, |rs1|, |rs2| and the result sign. Magnitudes and signs are taken only for DIV/REM; DIVU/REMU use raw values.
  - Clear the remainder accumulator, set the iteration counter to 0, go to CALC.
  - busy=1 from edge N.
- CALC: one restoring-division step per cycle, MSB first, 32 cycles (counter 0..31).
  - Each step: shift {rem, quo} left by 1; trial = rem - divisor using a 33-bit subtract.
  - If trial is non-negative, keep it and set the quotient LSB.
  - At counter 31, go to FIX.
- FIX, one cycle, selects the architectural result:
  - DIV: quotient, negated if sign(rs1) != sign(rs2).
  - REM: remainder, negated if rs1 is negative.
  - DIVU / REMU: raw quotient / remainder.
- Special cases, which override the FIX result:
  - Divide by zero (rs2=0): DIV and DIVU return 0xFFFFFFFF; REM and REMU return the original rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE:
  - ready=we=1 for exactly one cycle, with wd and A3 valid; go to IDLE.
  - busy falls at the same edge ready falls.
- Latency: request accepted at edge N -> ready high during the cycle after edge N+34; throughput is one operation per 35 cycles.
- valid while busy=1 is ignored and not queued.
- A new valid may be accepted in the first IDLE cycle after DONE.
- wd and A3 hold their last values after DONE; consumers must qualify them with we.
- rd=0 is carried through unchanged; suppressing writes to x0 is the register file's job.
- All arithmetic is two's complement. Negating 0x80000000 yields 0x80000000 and needs no special handling.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined:
  - Divide-by-zero and signed-overflow cases are detected in IDLE, and the FSM goes IDLE -> DONE directly.
  - ready occurs in the cycle after edge N+1; result values are as specified above.
  - Also, if |rs1| < |rs2| after the unsigned/signed selection, the result is produced in that same cycle: quotient 0, remainder the original rs1.
- Undefined: every operation takes the full 35-cycle path, and special-case values are forced in FIX. Architectural results are identical in both builds.

Test Plan:
- DIVU rs1=100, rs2=7, rd=5 -> ready at N+35, we=1, A3=5, wd=14; REMU with the same operands -> wd=2.
- DIV rs1=-100 (0xFFFFFF9C), rs2=7 -> wd=0xFFFFFFF2 (-14); REM with the same operands -> wd=0xFFFFFFFE (-2).
- rs2=0, rs1=0x12345678: DIV and DIVU -> wd=0xFFFFFFFF; REM and REMU -> 0x12345678.
  - Check latency is 35 cycles without DIV_FAST_SPECIAL_EN and 2 cycles with it.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> wd=0x80000000; REM with the same operands -> wd=0.
- Assert valid continuously with changing operands during busy -> exactly one ready pulse per 35 cycles, each result matching the operands sampled in IDLE.
- Assert reset at CALC iteration 10 -> next cycle busy=0, ready=0, wd=0, no we pulse; a new request afterwards completes correctly.
